// File: rtl/serial_cmp_pkg.sv
// Shared types for the framed MSB-first serial comparator: FSM state
// encoding and the three-way compare result.
package serial_cmp_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DRAIN  = 2'd2
    } cmp_state_e;

    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    localparam cmp_res_t CMP_EQ = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    // Build a one-hot result from the two decision flags.
    function automatic cmp_res_t make_res(input logic lt, input logic gt);
        return '{lt: lt, eq: !lt && !gt, gt: gt};
    endfunction

endpackage

// File: rtl/serial_cmp_digit.sv
// Combinational compare of one DIGIT_W-bit digit pair. Inverting the top bit
// of both operands turns an unsigned compare into a two's-complement one,
// which is only meaningful on the most significant digit of a frame.
module serial_cmp_digit
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W = 1
) (
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               invert_msb,
    output cmp_res_t           res
);

    logic [DIGIT_W-1:0] flip;
    logic [DIGIT_W-1:0] a_m;
    logic [DIGIT_W-1:0] b_m;

    // Optional sign-bit inversion followed by an unsigned magnitude compare.
    always_comb begin
        flip              = '0;
        flip[DIGIT_W-1]   = invert_msb;
        a_m               = a ^ flip;
        b_m               = b ^ flip;
        res               = make_res(a_m < b_m, a_m > b_m);
    end

endmodule

// File: rtl/serial_comparator_msb_framed.sv
// Framed MSB-first serial comparator. Operands arrive DIGIT_W bits per beat,
// most significant digit first; the first differing digit decides the result.
// Build option: define SERIAL_CMP_SIGNED_EN to honour signed_mode (sampled on
// the first beat); without it signed_mode is ignored and all compares are
// unsigned.
module serial_comparator_msb_framed
    import serial_cmp_pkg::*;
#(
    parameter int DIGIT_W    = 1,
    parameter int MAX_DIGITS = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic               in_first,
    input  logic               in_last,
    input  logic [DIGIT_W-1:0] a,
    input  logic [DIGIT_W-1:0] b,
    input  logic               signed_mode,
    output logic               a_less_b,
    output logic               a_eq_b,
    output logic               a_greater_b,
    output logic               res_valid,
    output logic               res_lt,
    output logic               res_eq,
    output logic               res_gt,
    output logic               err_len,
    output logic               err_abort
);

    localparam int                CNT_W   = $clog2(MAX_DIGITS + 1);
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(MAX_DIGITS);
    localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);

    cmp_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              dec_lt_q, dec_lt_d;
    logic              dec_gt_q, dec_gt_d;
    cmp_res_t          res_q, res_d;
    logic              res_valid_q, res_valid_d;
    logic              err_len_q, err_len_d;
    logic              err_abort_q, err_abort_d;

    logic              invert_msb;
    cmp_res_t          beat_res;
    cmp_res_t          run_res;
    logic              use_beat;
    logic              overflow;
    logic              prev_lt, prev_gt;
    logic              run_lt, run_gt;
    logic              unused_beat_eq;

`ifdef SERIAL_CMP_SIGNED_EN
    assign invert_msb = signed_mode & in_first;
`else
    logic unused_signed_mode;
    assign unused_signed_mode = signed_mode;
    assign invert_msb         = 1'b0;
`endif

    serial_cmp_digit #(
        .DIGIT_W (DIGIT_W)
    ) u_digit (
        .a          (a),
        .b          (b),
        .invert_msb (invert_msb),
        .res        (beat_res)
    );

    assign unused_beat_eq = beat_res.eq;

    // Running result: fold the current digit into the decided flags; a new
    // frame starts from a clean slate, a decided frame ignores later digits.
    always_comb begin
        use_beat = in_valid & (in_first | (state_q == ST_ACTIVE));
        prev_lt  = in_first ? 1'b0 : dec_lt_q;
        prev_gt  = in_first ? 1'b0 : dec_gt_q;
        run_lt   = prev_lt | (~prev_gt & beat_res.lt);
        run_gt   = prev_gt | (~prev_lt & beat_res.gt);
        overflow = ~in_first & (cnt_q == CNT_MAX);
        if (use_beat) begin
            run_res = make_res(run_lt, run_gt);
        end else if (state_q == ST_IDLE) begin
            run_res = CMP_EQ;
        end else begin
            run_res = make_res(dec_lt_q, dec_gt_q);
        end
    end

    // Frame sequencing, beat counting, result capture and error pulses.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        dec_lt_d    = dec_lt_q;
        dec_gt_d    = dec_gt_q;
        res_d       = res_q;
        res_valid_d = 1'b0;
        err_len_d   = 1'b0;
        err_abort_d = 1'b0;
        if (in_valid) begin
            if (in_first && (state_q != ST_IDLE)) begin
                err_abort_d = 1'b1;
            end
            if (use_beat) begin
                if (overflow) begin
                    // Too many beats: discard the frame and swallow the rest.
                    err_len_d = 1'b1;
                    dec_lt_d  = 1'b0;
                    dec_gt_d  = 1'b0;
                    cnt_d     = '0;
                    state_d   = in_last ? ST_IDLE : ST_DRAIN;
                end else if (in_last) begin
                    res_valid_d = 1'b1;
                    res_d       = run_res;
                    dec_lt_d    = 1'b0;
                    dec_gt_d    = 1'b0;
                    cnt_d       = '0;
                    state_d     = ST_IDLE;
                end else begin
                    dec_lt_d = run_lt;
                    dec_gt_d = run_gt;
                    cnt_d    = in_first ? CNT_ONE : cnt_q + CNT_ONE;
                    state_d  = ST_ACTIVE;
                end
            end else if ((state_q == ST_DRAIN) && in_last) begin
                state_d = ST_IDLE;
            end
        end
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            dec_lt_q    <= 1'b0;
            dec_gt_q    <= 1'b0;
            res_q       <= CMP_EQ;
            res_valid_q <= 1'b0;
            err_len_q   <= 1'b0;
            err_abort_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            dec_lt_q    <= dec_lt_d;
            dec_gt_q    <= dec_gt_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            err_len_q   <= err_len_d;
            err_abort_q <= err_abort_d;
        end
    end

    assign a_less_b    = run_res.lt;
    assign a_eq_b      = run_res.eq;
    assign a_greater_b = run_res.gt;
    assign res_valid   = res_valid_q;
    assign res_lt      = res_q.lt;
    assign res_eq      = res_q.eq;
    assign res_gt      = res_q.gt;
    assign err_len     = err_len_q;
    assign err_abort   = err_abort_q;

endmodule

// File: tb/tb_serial_comparator_msb_framed.sv
// Directed bench for serial_comparator_msb_framed: a 1-bit-digit instance
// (MAX_DIGITS=32) and a 4-bit-digit instance (MAX_DIGITS=4) share stimulus;
// each scenario checks the instance it targets. Signed expectations follow
// SERIAL_CMP_SIGNED_EN.
module tb_serial_comparator_msb_framed;

    logic       clk;
    logic       rst_n;
    logic       in_valid, in_first, in_last, signed_mode;
    logic [3:0] a4, b4;

    logic lt1, eq1, gt1, res_valid1, res_lt1, res_eq1, res_gt1, err_len1, err_abort1;
    logic lt4, eq4, gt4, res_valid4, res_lt4, res_eq4, res_gt4, err_len4, err_abort4;

    int checks = 0;
    int errors = 0;

`ifdef SERIAL_CMP_SIGNED_EN
    localparam logic [2:0] SGN_RUN = 3'b100;
`else
    localparam logic [2:0] SGN_RUN = 3'b001;
`endif

    serial_comparator_msb_framed #(.DIGIT_W(1), .MAX_DIGITS(32)) dut1 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a4[0:0]), .b(b4[0:0]), .signed_mode(signed_mode),
        .a_less_b(lt1), .a_eq_b(eq1), .a_greater_b(gt1), .res_valid(res_valid1),
        .res_lt(res_lt1), .res_eq(res_eq1), .res_gt(res_gt1),
        .err_len(err_len1), .err_abort(err_abort1)
    );

    serial_comparator_msb_framed #(.DIGIT_W(4), .MAX_DIGITS(4)) dut4 (
        .clk(clk), .rst(rst_n), .in_valid(in_valid), .in_first(in_first),
        .in_last(in_last), .a(a4), .b(b4), .signed_mode(signed_mode),
        .a_less_b(lt4), .a_eq_b(eq4), .a_greater_b(gt4), .res_valid(res_valid4),
        .res_lt(res_lt4), .res_eq(res_eq4), .res_gt(res_gt4),
        .err_len(err_len4), .err_abort(err_abort4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic v, input logic f, input logic l,
                        input logic [3:0] av, input logic [3:0] bv, input logic sm);
        @(negedge clk);
        in_valid = v; in_first = f; in_last = l; a4 = av; b4 = bv; signed_mode = sm;
        #1;
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
        a4 = 4'h0; b4 = 4'h0; signed_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_regs", {res_valid4, res_lt4, res_eq4, res_gt4, err_len4, err_abort4}, 6'b001000);
        check_val("rst_run", {lt4, eq4, gt4}, 3'b010);
        @(negedge clk);
        rst_n = 1'b1;

        // A=1011, B=1001, one bit per beat.
        beat(1, 1, 0, 4'h1, 4'h1, 0); check_val("r19_b1", {lt1, eq1, gt1}, 3'b010); tick();
        beat(1, 0, 0, 4'h0, 4'h0, 0); check_val("r19_b2", {lt1, eq1, gt1}, 3'b010); tick();
        beat(1, 0, 0, 4'h1, 4'h0, 0); check_val("r19_b3", {lt1, eq1, gt1}, 3'b001); tick();
        beat(1, 0, 1, 4'h1, 4'h1, 0); check_val("r19_b4", {lt1, eq1, gt1}, 3'b001); tick();
        check_val("r19_res", {res_valid1, res_lt1, res_eq1, res_gt1}, 4'b1001);
        idle(); tick();
        check_val("r19_hold", {res_valid1, res_lt1, res_eq1, res_gt1}, 4'b0001);
        $display("frame r19 1011 vs 1001 res_gt=%0b", res_gt1);

        // 0x8F vs 0x7F, signed_mode=1.
        beat(1, 1, 0, 4'h8, 4'h7, 1); check_val("r20s_b1", {lt4, eq4, gt4}, SGN_RUN); tick();
        beat(1, 0, 1, 4'hF, 4'hF, 1); check_val("r20s_b2", {lt4, eq4, gt4}, SGN_RUN); tick();
        check_val("r20s_res", {res_valid4, res_lt4, res_eq4, res_gt4}, {1'b1, SGN_RUN});
        idle();
        $display("frame r20 signed 8F vs 7F lt=%0b gt=%0b", res_lt4, res_gt4);

        // Same operands, unsigned.
        beat(1, 1, 0, 4'h8, 4'h7, 0); check_val("r20u_b1", {lt4, eq4, gt4}, 3'b001); tick();
        beat(1, 0, 1, 4'hF, 4'hF, 0); tick();
        check_val("r20u_res", {res_valid4, res_lt4, res_eq4, res_gt4}, 4'b1001);
        idle();
        $display("frame r20 unsigned 8F vs 7F gt=%0b", res_gt4);

        // Single-beat frame, 5 vs 5.
        beat(1, 1, 1, 4'h5, 4'h5, 0); check_val("r21_run", {lt4, eq4, gt4}, 3'b010); tick();
        check_val("r21_res", {res_valid4, res_lt4, res_eq4, res_gt4, err_abort4}, 5'b10100);
        idle(); tick();
        check_val("r21_after", {res_valid4, lt4, eq4, gt4}, 4'b0010);
        $display("frame r21 single beat eq=%0b", res_eq4);

        // Beats without in_first while idle are dropped.
        beat(1, 0, 0, 4'h9, 4'h1, 0); check_val("r11_run", {lt4, eq4, gt4}, 3'b010); tick();
        check_val("r11_regs", {res_valid4, res_eq4, err_len4, err_abort4}, 4'b0100);
        beat(1, 0, 1, 4'h9, 4'h1, 0); tick();
        check_val("r11_last", {res_valid4, err_len4}, 2'b00);
        idle();
        $display("frame r11 dropped beats");

        // Six beats into a four-digit instance.
        for (int i = 1; i <= 6; i++) begin
            beat(1, i == 1, i == 6, 4'h1, 4'h1, 0);
            tick();
            check_val($sformatf("r22_len%0d", i), {31'd0, err_len4}, {31'd0, i == 5});
            check_val($sformatf("r22_rv%0d", i), {31'd0, res_valid4}, 32'd0);
        end
        idle();
        $display("frame r22 overlength frame");

        // Restart on beat 3 of an open frame.
        beat(1, 1, 0, 4'h3, 4'h1, 0); check_val("r23_b1", {lt4, eq4, gt4}, 3'b001); tick();
        beat(1, 0, 0, 4'h0, 4'h0, 0); tick();
        beat(1, 1, 0, 4'h2, 4'h4, 0); check_val("r23_b3", {lt4, eq4, gt4}, 3'b100); tick();
        check_val("r23_abort", {res_valid4, err_abort4}, 2'b01);
        beat(1, 0, 1, 4'h0, 4'h0, 0); check_val("r23_b4", {lt4, eq4, gt4}, 3'b100); tick();
        check_val("r23_res", {res_valid4, res_lt4, res_eq4, res_gt4, err_abort4}, 5'b11000);
        idle();
        $display("frame r23 abort then lt=%0b", res_lt4);

        // Reset in the middle of a frame, then a fresh 2 vs 3 frame.
        beat(1, 1, 0, 4'h7, 4'h1, 0); tick();
        beat(1, 0, 0, 4'h0, 4'h0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("r24_rst", {res_valid4, res_lt4, res_eq4, res_gt4, err_len4, err_abort4}, 6'b001000);
        check_val("r24_run", {lt4, eq4, gt4}, 3'b010);
        idle(); tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("r24_quiet", {res_valid4, err_len4, err_abort4}, 3'b000);
        beat(1, 1, 1, 4'h2, 4'h3, 0); check_val("r24_b1", {lt4, eq4, gt4}, 3'b100); tick();
        check_val("r24_res", {res_valid4, res_lt4, res_eq4, res_gt4, err_len4, err_abort4}, 6'b110000);
        idle(); tick();
        check_val("r24_hold", {res_valid4, res_lt4, res_eq4, res_gt4, err_len4, err_abort4}, 6'b010000);
        $display("frame r24 reset then 2 vs 3 lt=%0b", res_lt4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
